seg_readback_decoder: RTL and testbench

- Readback monitor for the multiplexed 7-segment display bus. It recovers hex digits and decimal points from the active-low segment/anode lines produced by the display path.
- Sits beside the display driver, tapping the same seg/an nets.
- Exposes captured digits per position plus an atomically updated full-frame word, for self-check and debug readout by the processor.

---
 rtl/seg_readback_decoder.sv | 166 ++++++++++++++++
 tb/tb_seg_readback_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_readback_decoder.sv
// seg_readback_decoder: recovers hex digits from a multiplexed 7-segment bus.
// Define SEG_READBACK_BLANK_EN to accept an all-dark digit as a legal blank.
module seg_readback_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_dot,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [4*NUM_DIGITS-1:0] frame_word,
  output logic                    frame_pulse,
  output logic                    capture_pulse,
  output logic                    pattern_err,
  output logic                    collision_err
);

  localparam int N = NUM_DIGITS;
  localparam logic [15:0] SC = 16'(STABLE_CYCLES);

  typedef enum logic {
    SEARCH = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [7:0]   s_seg, p_seg;
  logic [N-1:0] s_an, p_an, s_act;
  logic         s_vld;
  logic [15:0]  run, run_nx;
  logic [N-1:0] mask, mask_nx;

  logic s_one, s_multi, same, cont, restart, hit;
  logic do_cap, cap_ok, cap_err, frame_done;
  logic ok, blank;
  logic [3:0] code;

  logic [4*N-1:0] val_nx;
  logic [N-1:0]   dot_nx, vld_nx;

  // result is {ok, blank, code}
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b0;
    case (p)
      7'b0000001: r = {2'b10, 4'h0};
      7'b1001111: r = {2'b10, 4'h1};
      7'b0010010: r = {2'b10, 4'h2};
      7'b0000110: r = {2'b10, 4'h3};
      7'b1001100: r = {2'b10, 4'h4};
      7'b0100100: r = {2'b10, 4'h5};
      7'b0100000: r = {2'b10, 4'h6};
      7'b0001111: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0000100: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b1100000: r = {2'b10, 4'hB};
      7'b0110001: r = {2'b10, 4'hC};
      7'b1000010: r = {2'b10, 4'hD};
      7'b0110000: r = {2'b10, 4'hE};
      7'b0111000: r = {2'b10, 4'hF};
`ifdef SEG_READBACK_BLANK_EN
      7'b1111111: r = {2'b11, 4'h0};
`endif
      default:    r = 6'b0;
    endcase
    return r;
  endfunction

  // run describes p_*, the sample one cycle older than s_*
  always_comb begin
    s_act   = ~s_an;
    s_one   = s_vld && ($countones(s_act) == 1);
    s_multi = s_vld && ($countones(s_act) > 1);
    same    = (s_seg == p_seg) && (s_an == p_an);
    cont    = s_one && same;
    restart = !cont;
    hit     = (run == SC);
    if (cont) begin
      run_nx = (run == 16'hffff) ? run : run + 16'd1;
    end else begin
      run_nx = {15'd0, s_one};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      SEARCH: if (hit && !restart) state_nx = HOLD;
      HOLD:   if (restart) state_nx = SEARCH;
    endcase
  end

  always_comb begin
    {ok, blank, code} = decode(p_seg[6:0]);
    do_cap  = (state == SEARCH) && hit;
    cap_ok  = do_cap && ok;
    cap_err = do_cap && !ok;
    val_nx  = digit_val;
    dot_nx  = digit_dot;
    vld_nx  = digit_valid;
    mask_nx = mask;
    for (int k = 0; k < N; k++) begin
      if (do_cap && !p_an[k]) begin
        if (ok) begin
          val_nx[4*k +: 4] = blank ? 4'h0 : code;
          dot_nx[k]        = !blank && !p_seg[7];
          vld_nx[k]        = !blank;
          mask_nx[k]       = 1'b1;
        end else begin
          vld_nx[k] = 1'b0;
        end
      end
    end
    frame_done = cap_ok && (&mask_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg         <= '0;
      s_an          <= '0;
      s_vld         <= 1'b0;
      p_seg         <= '0;
      p_an          <= '0;
      run           <= '0;
      mask          <= '0;
      digit_val     <= '0;
      digit_dot     <= '0;
      digit_valid   <= '0;
      frame_word    <= '0;
      frame_pulse   <= 1'b0;
      capture_pulse <= 1'b0;
      pattern_err   <= 1'b0;
      collision_err <= 1'b0;
    end else begin
      s_seg         <= seg;
      s_an          <= an;
      s_vld         <= 1'b1;
      p_seg         <= s_seg;
      p_an          <= s_an;
      run           <= run_nx;
      mask          <= frame_done ? '0 : mask_nx;
      digit_val     <= val_nx;
      digit_dot     <= dot_nx;
      digit_valid   <= vld_nx;
      if (frame_done) frame_word <= val_nx;
      frame_pulse   <= frame_done;
      capture_pulse <= cap_ok;
      pattern_err   <= cap_err;
      collision_err <= s_multi;
    end
  end

endmodule

// File: tb/tb_seg_readback_decoder.sv
// tb_seg_readback_decoder: table vectors, corner sequences and random
// stimulus against a dwell-based reference model.
module tb_seg_readback_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] digit_val;
  logic [3:0]  digit_dot;
  logic [3:0]  digit_valid;
  logic [15:0] frame_word;
  logic        frame_pulse;
  logic        capture_pulse;
  logic        pattern_err;
  logic        collision_err;

  always #5 clk = ~clk;

  seg_readback_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg(seg),
    .an(an),
    .digit_val(digit_val),
    .digit_dot(digit_dot),
    .digit_valid(digit_valid),
    .frame_word(frame_word),
    .frame_pulse(frame_pulse),
    .capture_pulse(capture_pulse),
    .pattern_err(pattern_err),
    .collision_err(collision_err)
  );

  int total = 0;
  int bad   = 0;
  int n_cap, n_perr, n_coll, n_frame, frame_at;

  typedef struct {
    bit         v;
    logic [3:0] an;
    logic [7:0] seg;
    int         dw;
  } smp_t;

  smp_t       d1, d2;
  logic [3:0] m_val[ND];
  bit         m_dot[ND], m_vld[ND], m_mask[ND];
  logic [15:0] m_fw;
  bit         m_cap, m_perr, m_coll, m_frame;
  logic [6:0] pat[16];

  function automatic int nlow(input logic [3:0] a);
    int c = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) c++;
    return c;
  endfunction

  function automatic logic [15:0] m_valw();
    logic [15:0] w = '0;
    for (int i = 0; i < ND; i++) w[4*i +: 4] = m_val[i];
    return w;
  endfunction

  function automatic logic [3:0] pack_bits(input bit b[ND]);
    logic [3:0] w = '0;
    for (int i = 0; i < ND; i++) w[i] = b[i];
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ND; i++) begin
      m_val[i] = 4'h0; m_dot[i] = 0; m_vld[i] = 0; m_mask[i] = 0;
    end
    m_fw = '0; m_cap = 0; m_perr = 0; m_coll = 0; m_frame = 0;
  endtask

  // A dwell of SC identical one-hot samples ending at sample n is
  // reported two edges after n; collisions one edge after the sample.
  task automatic model_edge(input bit r, input logic [3:0] a,
                            input logic [7:0] s);
    smp_t nw;
    int   pos, code;
    bit   bl, full;
    nw.v = !r; nw.an = a; nw.seg = s; nw.dw = 0;
    if (nw.v && nlow(a) == 1)
      nw.dw = (d1.dw > 0 && d1.an == a && d1.seg == s) ? d1.dw + 1 : 1;
    m_cap = 0; m_perr = 0; m_frame = 0;
    if (r) begin
      model_clear();
      d2 = d1; d2.dw = 0; d1 = nw;
      return;
    end
    m_coll = d1.v && nlow(d1.an) > 1;
    if (d2.dw == SC) begin
      pos = 0;
      for (int i = 0; i < ND; i++) if (!d2.an[i]) pos = i;
      code = -1;
      for (int i = 0; i < 16; i++) if (pat[i] == d2.seg[6:0]) code = i;
      bl = 0;
`ifdef SEG_READBACK_BLANK_EN
      if (d2.seg[6:0] == 7'h7f) bl = 1;
`endif
      if (code >= 0 || bl) begin
        m_val[pos]  = bl ? 4'h0 : 4'(code);
        m_dot[pos]  = !bl && !d2.seg[7];
        m_vld[pos]  = !bl;
        m_mask[pos] = 1;
        m_cap       = 1;
        full = 1;
        for (int i = 0; i < ND; i++) if (!m_mask[i]) full = 0;
        if (full) begin
          m_fw = m_valw();
          m_frame = 1;
          for (int i = 0; i < ND; i++) m_mask[i] = 0;
        end
      end else begin
        m_vld[pos] = 0;
        m_perr = 1;
      end
    end
    d2 = d1; d1 = nw;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("digit_val", digit_val, m_valw());
    chk("digit_dot", {12'd0, digit_dot}, {12'd0, pack_bits(m_dot)});
    chk("digit_valid", {12'd0, digit_valid}, {12'd0, pack_bits(m_vld)});
    chk("frame_word", frame_word, m_fw);
    chk("frame_pulse", {15'd0, frame_pulse}, {15'd0, m_frame});
    chk("capture_pulse", {15'd0, capture_pulse}, {15'd0, m_cap});
    chk("pattern_err", {15'd0, pattern_err}, {15'd0, m_perr});
    chk("collision_err", {15'd0, collision_err}, {15'd0, m_coll});
  endtask

  task automatic step(input bit r, input logic [3:0] a, input logic [7:0] s);
    reset = r; an = a; seg = s;
    @(posedge clk);
    #1;
    model_edge(r, a, s);
    check_all();
    n_cap   += int'(capture_pulse);
    n_perr  += int'(pattern_err);
    n_coll  += int'(collision_err);
    n_frame += int'(frame_pulse);
    if (frame_pulse) frame_at = n_cap;
  endtask

  task automatic clr_cnt();
    n_cap = 0; n_perr = 0; n_coll = 0; n_frame = 0; frame_at = 0;
  endtask

  task automatic show(input logic [3:0] a, input logic [7:0] s, input int h);
    for (int i = 0; i < h; i++) step(0, a, s);
    step(0, 4'hf, 8'hff);
    step(0, 4'hf, 8'hff);
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int          hold;
    int          caps, perrs, colls, frames;
    logic [15:0] val;
    logic [3:0]  vld;
    logic [3:0]  dot;
    logic [15:0] fw;
  } vec_t;

  vec_t tv[8];
  int   first_at;
  logic [3:0] ra, oh1, oh2;
  logic [7:0] rs;
  int   rh;
  bit   blank_build;

  initial begin
    pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    blank_build = 0;
`ifdef SEG_READBACK_BLANK_EN
    blank_build = 1;
`endif
    tv[0] = '{4'he, 8'b1_0010010, 10, 1, 0, 0, 0, 16'h0002, 4'b0001, 4'b0000, 16'h0000};
    tv[1] = '{4'hd, 8'b0_0000110, 3,  0, 0, 0, 0, 16'h0002, 4'b0001, 4'b0000, 16'h0000};
    tv[2] = '{4'hd, 8'b0_0000110, 4,  1, 0, 0, 0, 16'h0032, 4'b0011, 4'b0010, 16'h0000};
    tv[3] = '{4'hb, 8'b1_1111110, 6,  0, 1, 0, 0, 16'h0032, 4'b0011, 4'b0010, 16'h0000};
    if (blank_build)
      tv[4] = '{4'hb, 8'hff, 6, 1, 0, 0, 0, 16'h0032, 4'b0011, 4'b0010, 16'h0000};
    else
      tv[4] = '{4'hb, 8'hff, 6, 0, 1, 0, 0, 16'h0032, 4'b0011, 4'b0010, 16'h0000};
    tv[5] = '{4'hc, 8'b1_0000001, 3, 0, 0, 3, 0, 16'h0032, 4'b0011, 4'b0010, 16'h0000};
    if (blank_build) begin
      tv[6] = '{4'h7, 8'b1_0110000, 5, 1, 0, 0, 1, 16'hE032, 4'b1011, 4'b0010, 16'hE032};
      tv[7] = '{4'hb, 8'b1_1001100, 5, 1, 0, 0, 0, 16'hE432, 4'b1111, 4'b0010, 16'hE032};
    end else begin
      tv[6] = '{4'h7, 8'b1_0110000, 5, 1, 0, 0, 0, 16'hE032, 4'b1011, 4'b0010, 16'h0000};
      tv[7] = '{4'hb, 8'b1_1001100, 5, 1, 0, 0, 1, 16'hE432, 4'b1111, 4'b0010, 16'hE432};
    end

    d1 = '{0, 4'hf, 8'hff, 0};
    d2 = d1;
    model_clear();
    clr_cnt();

    step(1, 4'hf, 8'hff);
    step(1, 4'hf, 8'hff);
    chk("reset_val", digit_val, 16'h0);
    chk("reset_valid", {12'd0, digit_valid}, 16'h0);
    step(0, 4'hf, 8'hff);
    chk("post_reset_coll", {15'd0, collision_err}, 16'h0);

    for (int v = 0; v < 8; v++) begin
      clr_cnt();
      show(tv[v].an, tv[v].seg, tv[v].hold);
      chk($sformatf("tv%0d_caps", v), 16'(n_cap), 16'(tv[v].caps));
      chk($sformatf("tv%0d_perr", v), 16'(n_perr), 16'(tv[v].perrs));
      chk($sformatf("tv%0d_coll", v), 16'(n_coll), 16'(tv[v].colls));
      chk($sformatf("tv%0d_frames", v), 16'(n_frame), 16'(tv[v].frames));
      chk($sformatf("tv%0d_val", v), digit_val, tv[v].val);
      chk($sformatf("tv%0d_vld", v), {12'd0, digit_valid}, {12'd0, tv[v].vld});
      chk($sformatf("tv%0d_dot", v), {12'd0, digit_dot}, {12'd0, tv[v].dot});
      chk($sformatf("tv%0d_fw", v), frame_word, tv[v].fw);
    end

    // full frame from reset, with first-capture latency
    step(1, 4'hf, 8'hff);
    clr_cnt();
    first_at = 0;
    for (int i = 1; i <= 6; i++) begin
      step(0, 4'he, 8'b1_1001111);
      if (capture_pulse && first_at == 0) first_at = i;
    end
    chk("latency_edges", 16'(first_at), 16'd6);
    step(0, 4'hf, 8'hff);
    step(0, 4'hf, 8'hff);
    show(4'hd, 8'b1_0010010, 6);
    show(4'hb, 8'b1_0000110, 6);
    show(4'h7, 8'b1_1001100, 6);
    chk("ff_caps", 16'(n_cap), 16'd4);
    chk("ff_frames", 16'(n_frame), 16'd1);
    chk("ff_frame_at_cap", 16'(frame_at), 16'd4);
    chk("ff_word", frame_word, 16'h4321);

    // reset mid-frame discards the partial mask
    step(1, 4'hf, 8'hff);
    show(4'he, 8'b1_1001111, 6);
    show(4'hd, 8'b1_0010010, 6);
    step(1, 4'hf, 8'hff);
    chk("rst_val", digit_val, 16'h0);
    chk("rst_valid", {12'd0, digit_valid}, 16'h0);
    chk("rst_fw", frame_word, 16'h0);
    clr_cnt();
    show(4'hb, 8'b1_0000110, 6);
    show(4'h7, 8'b1_1001100, 6);
    chk("rst_no_frame", 16'(n_frame), 16'd0);
    show(4'he, 8'b1_1001111, 6);
    show(4'hd, 8'b1_0010010, 6);
    chk("rst_frame", 16'(n_frame), 16'd1);
    chk("rst_word", frame_word, 16'h4321);

    // random dwells checked cycle by cycle against the model
    for (int it = 0; it < 1500; it++) begin
      oh1 = ~(4'b0001 << $urandom_range(0, 3));
      oh2 = ~(4'b0001 << $urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ra = oh1;
        6, 7:             ra = 4'hf;
        8:                ra = oh1 & oh2;
        default:          ra = 4'($urandom);
      endcase
      rh = $urandom_range(0, 9);
      if (rh < 7)      rs = {1'($urandom), pat[$urandom_range(0, 15)]};
      else if (rh < 8) rs = {1'($urandom), 7'h7f};
      else             rs = 8'($urandom);
      rh = $urandom_range(1, 8);
      for (int i = 0; i < rh; i++) step(0, ra, rs);
      if ($urandom_range(0, 99) == 0) step(1, 4'hf, 8'hff);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
